// File: rtl/out_capture.sv
// Stream-to-memory capture: a 4-deep FIFO decouples s_valid/s_ready from mem_we/mem_ready. Words reach mem_we one cycle after acceptance.
// A full FIFO drops s_ready unless the head pops the same cycle. `define CAPTURE_CHECKSUM_EN to add an XOR checksum output.
module out_capture #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int CAP_LEN = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              done,
  output logic [ADDR_W:0]   word_count
`ifdef CAPTURE_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DRAIN, ST_DONE} state_t;

  localparam logic [ADDR_W:0] CAP_MAX = (ADDR_W+1)'(CAP_LEN);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fifo_q [4];
  logic [DATA_W-1:0] fifo_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   acc_q, acc_d, wc_q, wc_d;
  logic              done_q, done_d;
  logic              fifo_empty, fifo_full, push, pop, go_capture;
  logic [DATA_W-1:0] head;

  assign fifo_empty = (cnt_q == 3'd0);
  assign fifo_full  = (cnt_q == 3'd4);
  assign head       = fifo_q[rd_ptr_q];
  assign pop        = !fifo_empty && mem_ready;
  // A popping head frees a slot in the same cycle, so a full FIFO can still accept.
  assign s_ready    = (state_q == ST_CAPTURE) && (!fifo_full || pop) && (acc_q < CAP_MAX);
  assign push       = s_valid && s_ready;
  assign go_capture = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign mem_we     = !fifo_empty;
  assign mem_addr   = wc_q[ADDR_W-1:0];
  assign mem_wdata  = fifo_empty ? '0 : head;
  assign done       = done_q;
  assign word_count = wc_q;

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    acc_d    = acc_q;
    wc_d     = wc_q;
    done_d   = done_q;
    if (push) begin
      fifo_d[wr_ptr_q] = s_data;
      wr_ptr_d         = wr_ptr_q + 2'd1;
      acc_d            = acc_q + CNT_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
      wc_d     = wc_q + CNT_ONE;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      ST_CAPTURE: if (push && (s_last || (acc_d == CAP_MAX))) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (cnt_d == 3'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (go_capture) begin
      state_d  = ST_CAPTURE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      acc_d    = '0;
      wc_d     = '0;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      wc_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wc_q     <= wc_d;
      done_q   <= done_d;
    end
  end

`ifdef CAPTURE_CHECKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (go_capture) cksum_d = '0;
    else if (pop)   cksum_d = cksum_q ^ head;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cksum_q <= '0;
    else        cksum_q <= cksum_d;
  end

  assign checksum = cksum_q;
`endif

endmodule

// File: doc/out_capture.md
OUT_CAPTURE -- requirements
Module: out_capture

Interface
REQ-001 Parameter DATA_W, default 32, width of stream data and memory write data.
REQ-002 Parameter ADDR_W, default 10, width of memory word address.
REQ-003 Parameter CAP_LEN, default 1024, max words captured per run (1..2^ADDR_W).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; arms a capture run.
REQ-007 s_valid  input  1  upstream word valid.
REQ-008 s_data  input  DATA_W  upstream word.
REQ-009 s_last  input  1  marks final word of run; qualified by s_valid.
REQ-010 s_ready  output  1  block can accept a word this cycle.
REQ-011 mem_we  output  1  output-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  output-memory word address.
REQ-013 mem_wdata  output  DATA_W  output-memory write data.
REQ-014 mem_ready  input  1  memory accepts write when mem_we && mem_ready.
REQ-015 done  output  1  level; run complete, all words committed to memory.
REQ-016 word_count  output  ADDR_W+1  words committed in current/last run.

Function
REQ-017 States IDLE, CAPTURE, DRAIN, DONE; reset enters IDLE.
REQ-018 IDLE: s_ready=0, mem_we=0; start -> CAPTURE, clears word_count, write pointer, FIFO, done.
REQ-019 CAPTURE: stream word accepted when s_valid && s_ready; pushed into 4-entry FIFO.
REQ-020 s_ready = 1 in CAPTURE when FIFO not full and accepted count < CAP_LEN; 0 otherwise.
REQ-021 Simultaneous push and pop on full FIFO: pop wins, push accepted same cycle (s_ready stays 1 if FIFO full but head is popping).
REQ-022 FIFO head drives mem_wdata; mem_we = FIFO not empty; mem_addr = word_count[ADDR_W-1:0].
REQ-023 On mem_we && mem_ready: pop head, word_count += 1 same edge.
REQ-024 Latency: word accepted at edge N with empty FIFO appears on mem_we in cycle N+1.
REQ-025 CAPTURE -> DRAIN when accepted word has s_last=1 or accepted count reaches CAP_LEN; further s_valid ignored (s_ready=0).
REQ-026 DRAIN -> DONE on the edge the final FIFO word is written; done=1 from next cycle.
REQ-027 DONE: done held 1, mem_we=0, s_ready=0 until start; start in DONE -> CAPTURE, done=0 next cycle.
REQ-028 start in CAPTURE or DRAIN ignored.
REQ-029 mem_ready held low: FIFO fills, s_ready drops, no data lost or duplicated.
REQ-030 Address never wraps: at most CAP_LEN writes per run.

Reset
REQ-031 reset low asynchronously forces IDLE, FIFO empty, pointers 0, word_count=0, done=0, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 reset asserted mid-run aborts run; no further writes; restart only via start after reset release.

Configuration
REQ-033 Macro CAPTURE_CHECKSUM_EN defined: adds output checksum [DATA_W], cleared on start/reset, XOR of every committed word, stable while done=1.
REQ-034 Macro undefined: no checksum port or logic; all other behaviour identical.

Verification
REQ-035 start, 8 words 0x1..0x8 last on 8th, mem_ready=1 -> addr 0..7 written in order, done=1 two cycles after last accept, word_count=8.
REQ-036 CAP_LEN=16, 20 words offered no s_last -> exactly 16 writes, s_ready=0 after 16th accept, done=1.
REQ-037 mem_ready=0 for 10 cycles during stream -> s_ready=0 after 4 words buffered, all words written once in order after release.
REQ-038 reset pulsed low after 3 of 8 writes -> outputs zero immediately, done stays 0, new start writes from addr 0.
REQ-039 Run completes, start again with 4 words 0xA..0xD -> done drops next cycle, addr 0..3 rewritten, word_count=4.
REQ-040 CAPTURE_CHECKSUM_EN, words 0x1,0x2,0x4 -> checksum=0x7 when done=1.
